ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage; consumes ID/EX register outputs and produces the registered EX/MEM pipeline register.
- Contains operand forwarding, a 4-bit-coded ALU, branch/jump resolution, and a multi-cycle shift-add multiplier FSM.
- The multiplier holds the upstream pipeline through `ex_busy`.

Parameters:
- XLEN, 32, datapath width.
- MUL_CYCLES, 32, multiplier iterations; must equal XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ex_pc_in  in  32  PC of instruction in EX
- ex_pc_plus_4_in  in  32  PC+4
- ex_rs1_data_in, ex_rs2_data_in  in  32 each  register-file operands
- ex_imm_in  in  32  immediate
- ex_rs1_addr_in, ex_rs2_addr_in, ex_rd_addr_in  in  5 each  register addresses
- ex_instruction_in  in  32  debug copy
- ex_mem_read_in, ex_mem_write_in, ex_reg_write_in, ex_MemToReg_in, ex_ALUSrc_in, ex_Branch_in, ex_WriteFromPC_in  in  1 each  control
- ex_ALUCtrl_in  in  4  ALU op
- fwd_mem_rd_in  in  5  EX/MEM destination
- fwd_mem_reg_write_in  in  1  EX/MEM write enable
- fwd_mem_data_in  in  32  EX/MEM result
- fwd_wb_rd_in  in  5  MEM/WB destination
- fwd_wb_reg_write_in  in  1  MEM/WB write enable
- fwd_wb_data_in  in  32  MEM/WB writeback data
- ex_busy_out  out  1  hold request to hazard unit; freezes PC, IF/ID and ID/EX without inserting a bubble
- ex_branch_taken_out  out  1  combinational redirect
- ex_branch_target_out  out  32  combinational redirect target
- mem_alu_result_out, mem_write_data_out, mem_instruction_out  out  32 each  EX/MEM register
- mem_rd_addr_out  out  5  EX/MEM register
- mem_mem_read_out, mem_mem_write_out, mem_reg_write_out, mem_MemToReg_out  out  1 each  EX/MEM register

Behaviour:
- Reset: all EX/MEM outputs are 0, except `mem_instruction_out` = 0x00000013. FSM goes to IDLE, `ex_busy_out` = 0, counter = 0. Reset asserted mid-multiply aborts the multiply immediately.
- Forwarding, per operand:
  - Use `fwd_mem_data_in` if `fwd_mem_reg_write_in` is set, `fwd_mem_rd_in` ≠ 0 and it matches the source address.
  - Else use `fwd_wb_data_in` under the same rule with the WB fields.
  - Else use the register-file value.
  - MEM wins over WB. x0 is never forwarded.
- Operands: A = forwarded rs1. B = `ex_imm_in` if ALUSrc, else forwarded rs2. `mem_write_data_out` = forwarded rs2.
- ALUCtrl codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is B[4:0].
  - 8 SLT signed, 9 SLTU; result is 32-bit 0 or 1.
  - A MUL, low 32 bits of A*B.
  - B pass B.
  - C–F: result 0 (F is the pipeline NOP code).
  - All arithmetic wraps modulo 2^32.
- Result select: if WriteFromPC, result = `ex_pc_plus_4_in`; else the ALU result.
- Branch: `ex_branch_taken_out` = (Branch AND A == forwarded rs2) OR WriteFromPC. Target = `ex_pc_in` + `ex_imm_in`, wrapping. Both are forced to 0 while the FSM is not IDLE.
- Non-MUL ops: single cycle; the EX/MEM register captures every posedge while in IDLE.
- Multiplier FSM states:
  - IDLE:
    - On ALUCtrl = A with WriteFromPC = 0: latch A into multiplicand, B into multiplier, zero accumulator, counter = 0, latch rd/control/instruction, go to BUSY.
    - `ex_busy_out` is combinationally 1 in this start cycle.
    - The EX/MEM register captures a bubble (all controls 0, instruction 0x13).
  - BUSY:
    - `ex_busy_out` = 1.
    - Each cycle: if multiplier[0], add multiplicand to the accumulator; shift multiplicand left 1 and multiplier right 1; counter++.
    - When the counter reaches MUL_CYCLES−1, go to DONE.
    - The EX/MEM register captures a bubble every cycle.
  - DONE:
    - `ex_busy_out` = 0.
    - The EX/MEM register captures the accumulator plus the latched rd/control/instruction.
    - Go to IDLE; no restart even though ID/EX may still hold the same MUL this cycle, since it advances on this edge.
- Latency: MUL result appears in EX/MEM MUL_CYCLES+2 edges after first presentation. Upstream is held MUL_CYCLES+1 cycles.
- Latched operands isolate the multiply from forwarding sources draining during BUSY.

Optional Feature:
- EX_MUL_EN defined: multiplier FSM is present as described.
- EX_MUL_EN undefined:
  - No FSM.
  - ALUCtrl A yields result 0 in a single cycle.
  - `ex_busy_out` is tied to 0.
  - Branch outputs are never masked.

Test Plan:
- ADD x3,x1,x2 with rs1 = 5, rs2 = 7, no forwarding → next edge `mem_alu_result_out` = 12, `mem_rd_addr_out` = 3, `mem_reg_write_out` = 1.
- rs1 = 4 with MEM fwd rd = 4 data 0xAA and WB fwd rd = 4 data 0xBB, op pass-rs1 via ADD with imm 0 → result 0xAA. Repeat with the MEM rd = 0 → result 0xBB.
- Branch = 1, A = B = 0x10, pc = 0x100, imm = 0x20 → `ex_branch_taken_out` = 1, target 0x120. Change B to 0x11 → taken = 0.
- MUL 0xFFFFFFFF × 3 → `ex_busy_out` high 33 cycles, EX/MEM bubbles during busy, then `mem_alu_result_out` = 0xFFFFFFFD, and no second multiply start.
- Assert rst at BUSY cycle 10 → `ex_busy_out` = 0 and `mem_instruction_out` = 0x13 immediately. After release, a new ADD completes normally.
- SRA with A = 0x80000000, B = 4 → 0xF8000000. SLTU with A = 1, B = 0xFFFFFFFF → 1. SLT with the same operands → 0.

Source files
------------

// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding taps, redirect outputs and the EX/MEM register of the execute stage.
interface ex_stage_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] ex_pc_in;
  logic [XLEN-1:0] ex_pc_plus_4_in;
  logic [XLEN-1:0] ex_rs1_data_in;
  logic [XLEN-1:0] ex_rs2_data_in;
  logic [XLEN-1:0] ex_imm_in;
  logic [4:0]      ex_rs1_addr_in;
  logic [4:0]      ex_rs2_addr_in;
  logic [4:0]      ex_rd_addr_in;
  logic [31:0]     ex_instruction_in;
  logic            ex_mem_read_in;
  logic            ex_mem_write_in;
  logic            ex_reg_write_in;
  logic            ex_MemToReg_in;
  logic            ex_ALUSrc_in;
  logic            ex_Branch_in;
  logic            ex_WriteFromPC_in;
  logic [3:0]      ex_ALUCtrl_in;
  logic [4:0]      fwd_mem_rd_in;
  logic            fwd_mem_reg_write_in;
  logic [XLEN-1:0] fwd_mem_data_in;
  logic [4:0]      fwd_wb_rd_in;
  logic            fwd_wb_reg_write_in;
  logic [XLEN-1:0] fwd_wb_data_in;
  logic            ex_busy_out;
  logic            ex_branch_taken_out;
  logic [XLEN-1:0] ex_branch_target_out;
  logic [XLEN-1:0] mem_alu_result_out;
  logic [XLEN-1:0] mem_write_data_out;
  logic [31:0]     mem_instruction_out;
  logic [4:0]      mem_rd_addr_out;
  logic            mem_mem_read_out;
  logic            mem_mem_write_out;
  logic            mem_reg_write_out;
  logic            mem_MemToReg_out;

  modport master (
    output ex_pc_in, ex_pc_plus_4_in, ex_rs1_data_in, ex_rs2_data_in, ex_imm_in,
           ex_rs1_addr_in, ex_rs2_addr_in, ex_rd_addr_in, ex_instruction_in,
           ex_mem_read_in, ex_mem_write_in, ex_reg_write_in, ex_MemToReg_in,
           ex_ALUSrc_in, ex_Branch_in, ex_WriteFromPC_in, ex_ALUCtrl_in,
           fwd_mem_rd_in, fwd_mem_reg_write_in, fwd_mem_data_in,
           fwd_wb_rd_in, fwd_wb_reg_write_in, fwd_wb_data_in,
    input  ex_busy_out, ex_branch_taken_out, ex_branch_target_out,
           mem_alu_result_out, mem_write_data_out, mem_instruction_out, mem_rd_addr_out,
           mem_mem_read_out, mem_mem_write_out, mem_reg_write_out, mem_MemToReg_out
  );

  modport slave (
    input  ex_pc_in, ex_pc_plus_4_in, ex_rs1_data_in, ex_rs2_data_in, ex_imm_in,
           ex_rs1_addr_in, ex_rs2_addr_in, ex_rd_addr_in, ex_instruction_in,
           ex_mem_read_in, ex_mem_write_in, ex_reg_write_in, ex_MemToReg_in,
           ex_ALUSrc_in, ex_Branch_in, ex_WriteFromPC_in, ex_ALUCtrl_in,
           fwd_mem_rd_in, fwd_mem_reg_write_in, fwd_mem_data_in,
           fwd_wb_rd_in, fwd_wb_reg_write_in, fwd_wb_data_in,
    output ex_busy_out, ex_branch_taken_out, ex_branch_target_out,
           mem_alu_result_out, mem_write_data_out, mem_instruction_out, mem_rd_addr_out,
           mem_mem_read_out, mem_mem_write_out, mem_reg_write_out, mem_MemToReg_out
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch resolution and the EX/MEM register.
// EX_MUL_EN adds a shift-add multiplier FSM that holds upstream via ex_busy_out.
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic    clk,
  input  logic    rst,
  ex_stage_if.slave bus
);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  if (MUL_CYCLES != XLEN) begin : g_cfg_check
    $error("ex_stage: MUL_CYCLES must equal XLEN");
  end

  logic [XLEN-1:0] op_a, rs2_fwd, op_b, alu_res, ex_result;
  logic            mem_hit_rs1, wb_hit_rs1, mem_hit_rs2, wb_hit_rs2;
  logic            raw_taken;
  logic [XLEN-1:0] raw_target;

  // MEM stage is younger than WB, so it wins; x0 is hardwired and never forwarded.
  assign mem_hit_rs1 = bus.fwd_mem_reg_write_in && (bus.fwd_mem_rd_in != 5'd0) &&
                       (bus.fwd_mem_rd_in == bus.ex_rs1_addr_in);
  assign wb_hit_rs1  = bus.fwd_wb_reg_write_in && (bus.fwd_wb_rd_in != 5'd0) &&
                       (bus.fwd_wb_rd_in == bus.ex_rs1_addr_in);
  assign mem_hit_rs2 = bus.fwd_mem_reg_write_in && (bus.fwd_mem_rd_in != 5'd0) &&
                       (bus.fwd_mem_rd_in == bus.ex_rs2_addr_in);
  assign wb_hit_rs2  = bus.fwd_wb_reg_write_in && (bus.fwd_wb_rd_in != 5'd0) &&
                       (bus.fwd_wb_rd_in == bus.ex_rs2_addr_in);

  always_comb begin
    op_a = bus.ex_rs1_data_in;
    if (mem_hit_rs1)     op_a = bus.fwd_mem_data_in;
    else if (wb_hit_rs1) op_a = bus.fwd_wb_data_in;
  end

  always_comb begin
    rs2_fwd = bus.ex_rs2_data_in;
    if (mem_hit_rs2)     rs2_fwd = bus.fwd_mem_data_in;
    else if (wb_hit_rs2) rs2_fwd = bus.fwd_wb_data_in;
  end

  assign op_b = bus.ex_ALUSrc_in ? bus.ex_imm_in : rs2_fwd;

  // Code A is produced by the multiplier FSM, never by this combinational path.
  always_comb begin
    alu_res = '0;
    case (bus.ex_ALUCtrl_in)
      4'h0:    alu_res = op_a + op_b;
      4'h1:    alu_res = op_a - op_b;
      4'h2:    alu_res = op_a & op_b;
      4'h3:    alu_res = op_a | op_b;
      4'h4:    alu_res = op_a ^ op_b;
      4'h5:    alu_res = op_a << op_b[4:0];
      4'h6:    alu_res = op_a >> op_b[4:0];
      4'h7:    alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      4'h8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'h9:    alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'hB:    alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  assign ex_result  = bus.ex_WriteFromPC_in ? bus.ex_pc_plus_4_in : alu_res;
  assign raw_taken  = (bus.ex_Branch_in && (op_a == rs2_fwd)) || bus.ex_WriteFromPC_in;
  assign raw_target = bus.ex_pc_in + bus.ex_imm_in;

  logic            mul_hold;
  logic            mul_done;
  logic [XLEN-1:0] mul_acc;
  logic [XLEN-1:0] mul_wdata;
  logic [31:0]     mul_instr;
  logic [4:0]      mul_rd;
  logic [3:0]      mul_ctrl;

`ifdef EX_MUL_EN
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t      state;
  logic [XLEN-1:0] mcand, mplier;
  logic [CW-1:0]   cnt;
  logic            mul_start;

  assign mul_start = (state == IDLE) && (bus.ex_ALUCtrl_in == 4'hA) && !bus.ex_WriteFromPC_in;
  assign mul_hold  = (state == BUSY) || mul_start;
  assign mul_done  = (state == DONE);

  // Gated by rst so an aborted multiply drops the hold even while ID/EX still shows the MUL.
  assign bus.ex_busy_out          = !rst && mul_hold;
  assign bus.ex_branch_taken_out  = (state == IDLE) && raw_taken;
  assign bus.ex_branch_target_out = (state == IDLE) ? raw_target : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      mul_acc   <= '0;
      mul_wdata <= '0;
      mul_instr <= NOP_INSTR;
      mul_rd    <= '0;
      mul_ctrl  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_start) begin
            mcand     <= op_a;
            mplier    <= op_b;
            mul_acc   <= '0;
            cnt       <= '0;
            mul_wdata <= rs2_fwd;
            mul_instr <= bus.ex_instruction_in;
            mul_rd    <= bus.ex_rd_addr_in;
            mul_ctrl  <= {bus.ex_mem_read_in, bus.ex_mem_write_in,
                          bus.ex_reg_write_in, bus.ex_MemToReg_in};
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mplier[0]) mul_acc <= mul_acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(MUL_CYCLES - 1)) state <= DONE;
        end
        // ID/EX advances on this edge, so the same MUL is not restarted.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign mul_hold  = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_acc   = '0;
  assign mul_wdata = '0;
  assign mul_instr = NOP_INSTR;
  assign mul_rd    = '0;
  assign mul_ctrl  = '0;

  assign bus.ex_busy_out          = 1'b0;
  assign bus.ex_branch_taken_out  = raw_taken;
  assign bus.ex_branch_target_out = raw_target;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_alu_result_out  <= '0;
      bus.mem_write_data_out  <= '0;
      bus.mem_instruction_out <= NOP_INSTR;
      bus.mem_rd_addr_out     <= '0;
      bus.mem_mem_read_out    <= 1'b0;
      bus.mem_mem_write_out   <= 1'b0;
      bus.mem_reg_write_out   <= 1'b0;
      bus.mem_MemToReg_out    <= 1'b0;
    end else if (mul_done) begin
      bus.mem_alu_result_out  <= mul_acc;
      bus.mem_write_data_out  <= mul_wdata;
      bus.mem_instruction_out <= mul_instr;
      bus.mem_rd_addr_out     <= mul_rd;
      {bus.mem_mem_read_out, bus.mem_mem_write_out,
       bus.mem_reg_write_out, bus.mem_MemToReg_out} <= mul_ctrl;
    end else if (mul_hold) begin
      bus.mem_alu_result_out  <= '0;
      bus.mem_write_data_out  <= '0;
      bus.mem_instruction_out <= NOP_INSTR;
      bus.mem_rd_addr_out     <= '0;
      bus.mem_mem_read_out    <= 1'b0;
      bus.mem_mem_write_out   <= 1'b0;
      bus.mem_reg_write_out   <= 1'b0;
      bus.mem_MemToReg_out    <= 1'b0;
    end else begin
      bus.mem_alu_result_out  <= ex_result;
      bus.mem_write_data_out  <= rs2_fwd;
      bus.mem_instruction_out <= bus.ex_instruction_in;
      bus.mem_rd_addr_out     <= bus.ex_rd_addr_in;
      bus.mem_mem_read_out    <= bus.ex_mem_read_in;
      bus.mem_mem_write_out   <= bus.ex_mem_write_in;
      bus.mem_reg_write_out   <= bus.ex_reg_write_in;
      bus.mem_MemToReg_out    <= bus.ex_MemToReg_in;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: per-cycle check against a countdown-based behavioural model plus literal expectations.
module tb_ex_stage;
  localparam int MUL_CYCLES = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   go  = 1'b0;
  int   checks = 0;
  int   passes = 0;

  ex_stage_if #(.XLEN(32)) bus ();
  ex_stage #(.XLEN(32), .MUL_CYCLES(MUL_CYCLES)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] fwd_val(input logic [4:0] addr, input logic [31:0] rf);
    if (bus.fwd_mem_reg_write_in && addr != 5'd0 && bus.fwd_mem_rd_in == addr) return bus.fwd_mem_data_in;
    if (bus.fwd_wb_reg_write_in && addr != 5'd0 && bus.fwd_wb_rd_in == addr) return bus.fwd_wb_data_in;
    return rf;
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = a << b[4:0];
      4'h6: r = a >> b[4:0];
      4'h7: r = $unsigned($signed(a) >>> b[4:0]);
      4'h8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h9: r = (a < b) ? 32'd1 : 32'd0;
      4'hB: r = b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Expected EX/MEM register contents, and the number of edges still to go for a multiply in flight.
  logic [31:0] e_res = 0, e_wd = 0, e_instr = 32'h13;
  logic [4:0]  e_rd = 0;
  logic [3:0]  e_ctl = 0;
  int          mul_left = 0;
  logic [31:0] m_res, m_wd, m_instr;
  logic [4:0]  m_rd;
  logic [3:0]  m_ctl;

  task automatic m_bubble();
    e_res = 0; e_wd = 0; e_instr = 32'h13; e_rd = 0; e_ctl = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    logic [31:0] a, r2, b;
    if (rst) begin
      m_bubble();
      mul_left = 0;
    end else begin
      a  = fwd_val(bus.ex_rs1_addr_in, bus.ex_rs1_data_in);
      r2 = fwd_val(bus.ex_rs2_addr_in, bus.ex_rs2_data_in);
      b  = bus.ex_ALUSrc_in ? bus.ex_imm_in : r2;
`ifdef EX_MUL_EN
      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) begin
          e_res = m_res; e_wd = m_wd; e_instr = m_instr; e_rd = m_rd; e_ctl = m_ctl;
        end else m_bubble();
      end else if (bus.ex_ALUCtrl_in == 4'hA && !bus.ex_WriteFromPC_in) begin
        mul_left = MUL_CYCLES + 1;
        m_res = a * b; m_wd = r2; m_instr = bus.ex_instruction_in; m_rd = bus.ex_rd_addr_in;
        m_ctl = {bus.ex_mem_read_in, bus.ex_mem_write_in, bus.ex_reg_write_in, bus.ex_MemToReg_in};
        m_bubble();
      end else
`endif
      begin
        e_res   = bus.ex_WriteFromPC_in ? bus.ex_pc_plus_4_in : model_alu(bus.ex_ALUCtrl_in, a, b);
        e_wd    = r2;
        e_instr = bus.ex_instruction_in;
        e_rd    = bus.ex_rd_addr_in;
        e_ctl   = {bus.ex_mem_read_in, bus.ex_mem_write_in, bus.ex_reg_write_in, bus.ex_MemToReg_in};
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] a, r2, tgt;
    logic        tk, busy;
    if (go) begin
      a    = fwd_val(bus.ex_rs1_addr_in, bus.ex_rs1_data_in);
      r2   = fwd_val(bus.ex_rs2_addr_in, bus.ex_rs2_data_in);
      tk   = (bus.ex_Branch_in && a == r2) || bus.ex_WriteFromPC_in;
      tgt  = bus.ex_pc_in + bus.ex_imm_in;
      busy = 1'b0;
`ifdef EX_MUL_EN
      busy = !rst && (mul_left > 1 ||
             (mul_left == 0 && bus.ex_ALUCtrl_in == 4'hA && !bus.ex_WriteFromPC_in));
      if (mul_left > 0) begin tk = 1'b0; tgt = 0; end
`endif
      chk("m_busy",   {31'd0, bus.ex_busy_out}, {31'd0, busy});
      chk("m_taken",  {31'd0, bus.ex_branch_taken_out}, {31'd0, tk});
      chk("m_target", bus.ex_branch_target_out, tgt);
      chk("m_result", bus.mem_alu_result_out, e_res);
      chk("m_wdata",  bus.mem_write_data_out, e_wd);
      chk("m_instr",  bus.mem_instruction_out, e_instr);
      chk("m_rd",     {27'd0, bus.mem_rd_addr_out}, {27'd0, e_rd});
      chk("m_ctl",    {28'd0, bus.mem_mem_read_out, bus.mem_mem_write_out,
                       bus.mem_reg_write_out, bus.mem_MemToReg_out}, {28'd0, e_ctl});
    end
  end

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] a2, input logic [31:0] d2, input logic src,
                        input logic [31:0] imm, input logic [4:0] rd);
    bus.ex_ALUCtrl_in = op;
    bus.ex_rs1_addr_in = a1; bus.ex_rs1_data_in = d1;
    bus.ex_rs2_addr_in = a2; bus.ex_rs2_data_in = d2;
    bus.ex_ALUSrc_in = src; bus.ex_imm_in = imm; bus.ex_rd_addr_in = rd;
    bus.ex_instruction_in = 32'h1000_0000 | {20'd0, op, 3'd0, rd};
    bus.ex_reg_write_in = 1'b1; bus.ex_mem_read_in = 1'b0; bus.ex_mem_write_in = 1'b0;
    bus.ex_MemToReg_in = 1'b0; bus.ex_Branch_in = 1'b0; bus.ex_WriteFromPC_in = 1'b0;
    bus.ex_pc_in = 32'h0000_0080; bus.ex_pc_plus_4_in = 32'h0000_0084;
    bus.fwd_mem_reg_write_in = 1'b0; bus.fwd_mem_rd_in = 0; bus.fwd_mem_data_in = 0;
    bus.fwd_wb_reg_write_in = 1'b0; bus.fwd_wb_rd_in = 0; bus.fwd_wb_data_in = 0;
  endtask

  initial begin
    int cnt;
    set_op(4'hF, 0, 0, 0, 0, 0, 0, 0);
    bus.ex_reg_write_in = 1'b0;
    bus.ex_instruction_in = 32'h13;
    #2 rst = 1'b1;
    go = 1'b1;
    #1;
    chk("rst_instr",  bus.mem_instruction_out, 32'h13);
    chk("rst_result", bus.mem_alu_result_out, 32'h0);
    chk("rst_regwr",  {31'd0, bus.mem_reg_write_out}, 32'd0);
    chk("rst_busy",   {31'd0, bus.ex_busy_out}, 32'd0);
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;

    set_op(4'h0, 1, 5, 2, 7, 0, 0, 3);
    next();
    chk("add_result", bus.mem_alu_result_out, 32'd12);
    chk("add_rd",     {27'd0, bus.mem_rd_addr_out}, 32'd3);
    chk("add_regwr",  {31'd0, bus.mem_reg_write_out}, 32'd1);

    set_op(4'h0, 4, 32'h11, 5, 0, 1, 0, 6);
    bus.fwd_mem_reg_write_in = 1'b1; bus.fwd_mem_rd_in = 4; bus.fwd_mem_data_in = 32'hAA;
    bus.fwd_wb_reg_write_in = 1'b1;  bus.fwd_wb_rd_in = 4;  bus.fwd_wb_data_in = 32'hBB;
    next();
    chk("fwd_mem_wins", bus.mem_alu_result_out, 32'hAA);
    bus.fwd_mem_rd_in = 0;
    next();
    chk("fwd_wb", bus.mem_alu_result_out, 32'hBB);

    set_op(4'h0, 1, 1, 7, 9, 0, 0, 8);
    bus.fwd_wb_reg_write_in = 1'b1; bus.fwd_wb_rd_in = 7; bus.fwd_wb_data_in = 32'h55;
    next();
    chk("fwd_rs2_wdata", bus.mem_write_data_out, 32'h55);
    chk("fwd_rs2_sum",   bus.mem_alu_result_out, 32'h56);

    set_op(4'h0, 1, 32'h10, 2, 32'h10, 1, 32'h20, 0);
    bus.ex_Branch_in = 1'b1; bus.ex_reg_write_in = 1'b0; bus.ex_pc_in = 32'h100;
    #1;
    chk("br_taken",  {31'd0, bus.ex_branch_taken_out}, 32'd1);
    chk("br_target", bus.ex_branch_target_out, 32'h120);
    bus.ex_rs2_data_in = 32'h11;
    #1;
    chk("br_not_taken", {31'd0, bus.ex_branch_taken_out}, 32'd0);
    next();

    set_op(4'h0, 1, 3, 2, 4, 0, 32'h40, 1);
    bus.ex_WriteFromPC_in = 1'b1; bus.ex_pc_in = 32'h200; bus.ex_pc_plus_4_in = 32'h204;
    #1;
    chk("jal_taken",  {31'd0, bus.ex_branch_taken_out}, 32'd1);
    chk("jal_target", bus.ex_branch_target_out, 32'h240);
    next();
    chk("jal_link", bus.mem_alu_result_out, 32'h204);

    set_op(4'h7, 1, 32'h8000_0000, 0, 0, 1, 4, 9);
    next();
    chk("sra", bus.mem_alu_result_out, 32'hF800_0000);
    set_op(4'h9, 1, 1, 2, 32'hFFFF_FFFF, 0, 0, 10);
    next();
    chk("sltu", bus.mem_alu_result_out, 32'd1);
    set_op(4'h8, 1, 1, 2, 32'hFFFF_FFFF, 0, 0, 10);
    next();
    chk("slt", bus.mem_alu_result_out, 32'd0);
    set_op(4'h1, 1, 3, 2, 5, 0, 0, 11);
    next();
    chk("sub_wrap", bus.mem_alu_result_out, 32'hFFFF_FFFE);
    set_op(4'hB, 1, 3, 2, 5, 1, 32'hCAFE, 11);
    next();
    chk("pass_b", bus.mem_alu_result_out, 32'hCAFE);
    set_op(4'hC, 1, 3, 2, 5, 0, 0, 11);
    next();
    chk("code_c", bus.mem_alu_result_out, 32'd0);

`ifdef EX_MUL_EN
    set_op(4'hA, 1, 32'hFFFF_FFFF, 2, 3, 0, 0, 13);
    #1;
    cnt = 0;
    while (bus.ex_busy_out && cnt < 40) begin
      cnt++;
      if (cnt == 5) begin
        chk("mul_bubble_instr", bus.mem_instruction_out, 32'h13);
        chk("mul_bubble_regwr", {31'd0, bus.mem_reg_write_out}, 32'd0);
        bus.ex_WriteFromPC_in = 1'b1;
        #1;
        chk("mul_br_masked", {31'd0, bus.ex_branch_taken_out}, 32'd0);
        chk("mul_tgt_masked", bus.ex_branch_target_out, 32'd0);
        bus.ex_WriteFromPC_in = 1'b0;
      end
      next();
    end
    chk("mul_busy_cycles", cnt, 32'd33);
    next();
    set_op(4'hF, 0, 0, 0, 0, 0, 0, 0);
    bus.ex_reg_write_in = 1'b0;
    #1;
    chk("mul_result", bus.mem_alu_result_out, 32'hFFFF_FFFD);
    chk("mul_rd",     {27'd0, bus.mem_rd_addr_out}, 32'd13);
    chk("mul_no_restart", {31'd0, bus.ex_busy_out}, 32'd0);
    next();
    chk("mul_idle_after", {31'd0, bus.ex_busy_out}, 32'd0);

    set_op(4'hA, 1, 32'h1234, 2, 32'h10, 0, 0, 14);
    #1;
    repeat (10) next();
    chk("abort_busy_before", {31'd0, bus.ex_busy_out}, 32'd1);
`else
    set_op(4'hA, 1, 32'hFFFF_FFFF, 2, 3, 0, 0, 13);
    #1;
    chk("mul_off_busy", {31'd0, bus.ex_busy_out}, 32'd0);
    next();
    chk("mul_off_result", bus.mem_alu_result_out, 32'd0);
    chk("mul_off_rd",     {27'd0, bus.mem_rd_addr_out}, 32'd13);
    set_op(4'h0, 1, 32'h77, 2, 1, 0, 0, 14);
    next();
`endif
    #2 rst = 1'b1;
    #1;
    chk("abort_busy",  {31'd0, bus.ex_busy_out}, 32'd0);
    chk("abort_instr", bus.mem_instruction_out, 32'h13);
    chk("abort_regwr", {31'd0, bus.mem_reg_write_out}, 32'd0);
    set_op(4'h0, 1, 20, 2, 22, 0, 0, 12);
    @(negedge clk); #1;
    rst = 1'b0;
    next();
    chk("post_rst_add", bus.mem_alu_result_out, 32'd42);
    chk("post_rst_rd",  {27'd0, bus.mem_rd_addr_out}, 32'd12);

    set_op(4'hF, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) next();
    go = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d passes expected %0d", passes, checks);
    $fatal(1);
  end
endmodule
